// File: rtl/tdm_pkg.sv
// tdm_pkg: constants and types shared by both ends of the 8-channel TDM link.
//   NCH    - number of channels (slots) per frame
//   SEL_W  - width of the slot select bus driven to the demultiplexer
//   state_t- transmitter frame state
package tdm_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/slot_timer.sv
// slot_timer: counts enabled clock cycles within one TDM slot.
// Ports:
//   clk      in  rising-edge clock
//   rst      in  synchronous active-high reset
//   En       in  count enable (counter holds while low)
//   clear    in  hold the counter at zero (no frame in progress)
//   slot_end out high during the last enabled cycle of a slot
module slot_timer #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic En,
  input  logic clear,
  output logic slot_end
);

  localparam int            CW   = $clog2(SLOT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Only an enabled cycle can end a slot, so a frozen link never advances.
  assign slot_end = En && !clear && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (En) begin
      r_cnt <= slot_end ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: 8-to-1 time-division multiplexing transmitter.
// Accepts 8-bit words on a Load/Ready handshake and sends them LSB-first,
// one bit per slot, on F while S carries the slot index for the demux.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   En     in   1 = advance slots, 0 = freeze transmission
//   D      in   parallel word, D[k] goes out in slot k
//   Load   in   D valid; accepted when Load && Ready
//   Ready  out  holding register empty
//   F      out  serial data
//   S      out  current slot index
//   Sync   out  first cycle of slot 0 of each frame
//   Done   out  final cycle of slot 7 of each frame
module tdm_mux8_tx
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [NCH-1:0]   D,
  input  logic             Load,
  output logic             Ready,
  output logic             F,
  output logic [SEL_W-1:0] S,
  output logic             Sync,
  output logic             Done
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);

  state_t           r_state,   w_state_next;
  logic [NCH-1:0]   r_sr,      w_sr_next;
  logic [NCH-1:0]   r_hr,      w_hr_next;
  logic             r_hr_full, w_hr_full_next;
  logic             r_f,       w_f_next;
  logic [SEL_W-1:0] r_s,       w_s_next;
  logic             r_first,   w_first_next;

  logic             w_accept;
  logic             w_slot_end;
  logic             w_start;
  logic             w_hr_drain;
  logic [NCH-1:0]   w_start_word;
  logic [SEL_W-1:0] w_s_inc;

  slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_slot_timer (
    .clk     (clk),
    .rst     (rst),
    .En      (En),
    .clear   (r_state == IDLE),
    .slot_end(w_slot_end)
  );

  assign w_accept = Load && !r_hr_full;
  assign w_s_inc  = r_s + 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_sr_next      = r_sr;
    w_hr_next      = r_hr;
    w_hr_full_next = r_hr_full;
    w_f_next       = r_f;
    w_s_next       = r_s;
    w_first_next   = r_first;
    w_start        = 1'b0;
    w_hr_drain     = 1'b0;
    w_start_word   = r_hr;

    case (r_state)
      IDLE: begin
        // A parked word has priority over a fresh one when the link resumes.
        if (En && r_hr_full) begin
          w_start    = 1'b1;
          w_hr_drain = 1'b1;
        end else if (En && w_accept) begin
          w_start      = 1'b1;
          w_start_word = D;
        end
      end
      SHIFT: begin
        if (En) begin
          w_first_next = 1'b0;
        end
        if (w_slot_end) begin
          if (r_s == LAST_SLOT) begin
            if (r_hr_full) begin
              w_start    = 1'b1;
              w_hr_drain = 1'b1;
            end else if (w_accept) begin
              w_start      = 1'b1;
              w_start_word = D;
            end else begin
              w_state_next = IDLE;
              w_f_next     = 1'b0;
              w_s_next     = '0;
            end
          end else begin
            w_s_next = w_s_inc;
            w_f_next = r_sr[w_s_inc];
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_start) begin
      w_state_next = SHIFT;
      w_sr_next    = w_start_word;
      w_f_next     = w_start_word[0];
      w_s_next     = '0;
      w_first_next = 1'b1;
    end

    if (w_hr_drain) begin
      w_hr_full_next = 1'b0;
    end
    // Any accepted word not sent straight into sr is parked in hr.
    if (w_accept && !(w_start && !w_hr_drain)) begin
      w_hr_next      = D;
      w_hr_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_hr      <= '0;
      r_hr_full <= 1'b0;
      r_f       <= 1'b0;
      r_s       <= '0;
      r_first   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sr      <= w_sr_next;
      r_hr      <= w_hr_next;
      r_hr_full <= w_hr_full_next;
      r_f       <= w_f_next;
      r_s       <= w_s_next;
      r_first   <= w_first_next;
    end
  end

  assign Ready = !r_hr_full;
  assign F     = r_f;
  assign S     = r_s;
  // Sync lands on the first enabled cycle of slot 0; a frozen cycle shows 0.
  assign Sync  = (r_state == SHIFT) && r_first && En;
  assign Done  = (r_state == SHIFT) && w_slot_end && (r_s == LAST_SLOT);

endmodule

// File: tb/tb_tdm_mux8_tx.sv
module tb_tdm_mux8_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       En = 1'b0;
  logic [7:0] D = 8'h00;
  logic       Load = 1'b0;

  logic       Ready1, F1, Sync1, Done1;
  logic [2:0] S1;
  logic       Ready3, F3, Sync3, Done3;
  logic [2:0] S3;

  int checks = 0;
  int errors = 0;

  tdm_mux8_tx #(.SLOT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .En(En), .D(D), .Load(Load),
    .Ready(Ready1), .F(F1), .S(S1), .Sync(Sync1), .Done(Done1)
  );

  tdm_mux8_tx #(.SLOT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .En(En), .D(D), .Load(Load),
    .Ready(Ready3), .F(F3), .S(S3), .Sync(Sync3), .Done(Done3)
  );

  always #5 clk = ~clk;

  // Observation vectors: {Ready, F, S[2:0], Sync, Done}
  logic [6:0] obs1, obs3;
  assign obs1 = {Ready1, F1, S1, Sync1, Done1};
  assign obs3 = {Ready3, F3, S3, Sync3, Done3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; En = 1'b0; Load = 1'b0; D = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; En = 1'b1; Load = 1'b1; D = 8'hFF;
    tick(); tick();
    Load = 1'b0; En = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (obs1 !== 7'b1_0_000_0_0) begin
      errors++; $display("FAIL reset_dut1: obs=%b exp=%b", obs1, 7'b1000000);
    end
    checks++;
    if (obs3 !== 7'b1_0_000_0_0) begin
      errors++; $display("FAIL reset_dut3: obs=%b exp=%b", obs3, 7'b1000000);
    end
    $display("reset done");
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    logic [6:0] e;
    do_reset();
    w = 8'hA5;
    En = 1'b1; D = w; Load = 1'b1;
    tick();
    Load = 1'b0;
    $display("tx word %02h single frame", w);
    for (int k = 0; k < 8; k++) begin
      e = {1'b1, w[k], k[2:0], (k == 0), (k == 7)};
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL single_frame slot %0d: obs=%b exp=%b", k, obs1, e);
      end
      tick();
    end
    checks++;
    if (obs1 !== 7'b1000000) begin
      errors++; $display("FAIL single_frame_idle: obs=%b exp=%b", obs1, 7'b1000000);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1, wk;
    logic [6:0] e;
    do_reset();
    w0 = 8'h0F; w1 = 8'hF0;
    En = 1'b1; D = w0; Load = 1'b1;
    tick();
    D = w1;
    $display("tx word %02h then %02h back to back", w0, w1);
    for (int k = 0; k < 16; k++) begin
      wk = (k < 8) ? w0 : w1;
      e = {(k == 0 || k >= 8), wk[k % 8], k[2:0], ((k % 8) == 0), ((k % 8) == 7)};
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL back_to_back cycle %0d: obs=%b exp=%b", k, obs1, e);
      end
      tick();
      if (k == 0) Load = 1'b0;
    end
    checks++;
    if (obs1 !== 7'b1000000) begin
      errors++; $display("FAIL back_to_back_idle: obs=%b exp=%b", obs1, 7'b1000000);
    end
  endtask

  task automatic test_frame_end_load();
    logic [7:0] w0, w1, wk;
    logic [6:0] e;
    do_reset();
    w0 = 8'hC3; w1 = 8'h55;
    En = 1'b1; D = w0; Load = 1'b1;
    tick();
    Load = 1'b0;
    $display("tx word %02h then %02h on frame-end edge", w0, w1);
    for (int k = 0; k < 16; k++) begin
      if (k == 7) begin
        D = w1; Load = 1'b1;
      end
      wk = (k < 8) ? w0 : w1;
      e = {1'b1, wk[k % 8], k[2:0], ((k % 8) == 0), ((k % 8) == 7)};
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL frame_end_load cycle %0d: obs=%b exp=%b", k, obs1, e);
      end
      tick();
      if (k == 7) Load = 1'b0;
    end
    checks++;
    if (obs1 !== 7'b1000000) begin
      errors++; $display("FAIL frame_end_load_idle: obs=%b exp=%b", obs1, 7'b1000000);
    end
  endtask

  task automatic test_en_low_idle();
    logic [7:0] w;
    logic [6:0] e;
    do_reset();
    w = 8'h3C;
    En = 1'b0; D = w; Load = 1'b1;
    tick();
    Load = 1'b0;
    $display("tx word %02h held while disabled", w);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs1 !== 7'b0000000) begin
        errors++; $display("FAIL en_low_hold %0d: obs=%b exp=%b", k, obs1, 7'b0000000);
      end
      tick();
    end
    En = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      e = {1'b1, w[k], k[2:0], (k == 0), (k == 7)};
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL en_low_frame slot %0d: obs=%b exp=%b", k, obs1, e);
      end
      tick();
    end
    checks++;
    if (obs1 !== 7'b1000000) begin
      errors++; $display("FAIL en_low_idle: obs=%b exp=%b", obs1, 7'b1000000);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w0, w;
    logic [6:0] e;
    do_reset();
    w0 = 8'h0F;
    En = 1'b1; D = w0; Load = 1'b1;
    tick();
    D = 8'hF0;
    tick();
    Load = 1'b0;
    tick(); tick();
    e = {1'b0, w0[3], 3'd3, 1'b0, 1'b0};
    checks++;
    if (obs1 !== e) begin
      errors++; $display("FAIL mid_frame_slot3: obs=%b exp=%b", obs1, e);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset during slot 3 with holding register full");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs1 !== 7'b1000000) begin
        errors++; $display("FAIL mid_reset_idle %0d: obs=%b exp=%b", k, obs1, 7'b1000000);
      end
      tick();
    end
    w = 8'hA5;
    D = w; Load = 1'b1;
    tick();
    Load = 1'b0;
    $display("tx word %02h after reset", w);
    for (int k = 0; k < 8; k++) begin
      e = {1'b1, w[k], k[2:0], (k == 0), (k == 7)};
      checks++;
      if (obs1 !== e) begin
        errors++; $display("FAIL post_reset_frame slot %0d: obs=%b exp=%b", k, obs1, e);
      end
      tick();
    end
  endtask

  task automatic test_slot3_freeze();
    logic [7:0] w;
    logic [6:0] e;
    do_reset();
    w = 8'h81;
    En = 1'b1; D = w; Load = 1'b1;
    tick();
    Load = 1'b0;
    $display("tx word %02h with 3-cycle slots and freeze in slot 4", w);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (s == 4 && c == 1) begin
          En = 1'b0;
          for (int f = 0; f < 2; f++) begin
            e = {1'b1, w[4], 3'd4, 1'b0, 1'b0};
            checks++;
            if (obs3 !== e) begin
              errors++; $display("FAIL slot3_frozen %0d: obs=%b exp=%b", f, obs3, e);
            end
            tick();
          end
          En = 1'b1;
        end
        e = {1'b1, w[s], s[2:0], (s == 0 && c == 0), (s == 7 && c == 2)};
        checks++;
        if (obs3 !== e) begin
          errors++; $display("FAIL slot3 s%0d c%0d: obs=%b exp=%b", s, c, obs3, e);
        end
        tick();
      end
    end
    checks++;
    if (obs3 !== 7'b1000000) begin
      errors++; $display("FAIL slot3_idle: obs=%b exp=%b", obs3, 7'b1000000);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_end_load();
    test_en_low_idle();
    test_reset_mid_frame();
    test_slot3_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
